redc_share_arbiter: RTL and testbench

- Shares one 60-to-30-bit windowed modular reduction unit between NUM_REQ requesters (multiplier lanes) in the RLWE processor datapath.
- Round-robin arbitration per cycle; issues one 60-bit product per cycle into the unit.
- Delays the modulus-select bit so it is aligned with the unit's final stage.
- Tracks in-flight operations with a tag pipeline and returns tagged 30-bit results through a credit-protected output FIFO, because the reduction pipeline cannot stall.

---
 rtl/redc_share_if.sv | 30 +++
 rtl/redc_share_arbiter.sv | 126 ++++++++++++
 tb/tb_redc_share_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/redc_share_if.sv
// Handshake bundle between the requesters, the shared reduction unit and the
// result consumer of redc_share_arbiter.
interface redc_share_if #(
  parameter int NUM_REQ = 2
);
  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [60*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_msel;
  logic [59:0]           red_in;
  logic                  red_modulus_sel;
  logic [29:0]           red_out;
  logic                  res_valid;
  logic                  res_ready;
  logic [29:0]           res_data;
  logic [TAG_W-1:0]      res_tag;
  logic                  busy;

  modport slave (
    input  req_valid, req_data, req_msel, red_out, res_ready,
    output req_ready, red_in, red_modulus_sel, res_valid, res_data, res_tag, busy
  );

  modport master (
    output req_valid, req_data, req_msel, red_out, res_ready,
    input  req_ready, red_in, red_modulus_sel, res_valid, res_data, res_tag, busy
  );
endinterface

// File: rtl/redc_share_arbiter.sv
// Round-robin sharing of one non-stallable 60->30 bit reduction unit with a
// credit-protected tagged result FIFO. Define REDC_SHARE_PERF_EN for perf counters.
module redc_share_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int RED_LATENCY = 3,
  parameter int SEL_DELAY   = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  redc_share_if.slave bus
`ifdef REDC_SHARE_PERF_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_stall
`endif
);
  localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;

  typedef struct packed {
    logic [29:0]      data;
    logic [TAG_W-1:0] tag;
  } res_t;

  logic [RED_LATENCY-1:0]            vld_pipe;
  logic [RED_LATENCY-1:0][TAG_W-1:0] tag_pipe;
  logic [SEL_DELAY-1:0]              msel_pipe;
  logic [TAG_W-1:0]                  rr_ptr, rr_next, gnt_idx;
  logic                              gnt_any, credit_ok, push, pop;
  logic [AW-1:0]                     wr_ptr, rd_ptr;
  logic [CW-1:0]                     fifo_count;
  res_t                              fifo_mem [FIFO_DEPTH];

  // Every op in the pipe already owns a FIFO slot, so nothing can be dropped.
  assign credit_ok = rst_n && ((int'(fifo_count) + $countones(vld_pipe)) < FIFO_DEPTH);

  always_comb begin
    int               idx;
    logic [TAG_W-1:0] idx_t;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    idx_t   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_t = TAG_W'(idx);
      if (!gnt_any && credit_ok && bus.req_valid[idx_t]) begin
        gnt_any = 1'b1;
        gnt_idx = idx_t;
      end
    end
  end

  assign bus.req_ready = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign rr_next       = (gnt_idx == TAG_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.red_in          <= '0;
      bus.red_modulus_sel <= 1'b0;
      vld_pipe            <= '0;
      tag_pipe            <= '0;
      msel_pipe           <= '0;
      rr_ptr              <= '0;
    end else begin
      vld_pipe[0]  <= gnt_any;
      tag_pipe[0]  <= gnt_idx;
      msel_pipe[0] <= gnt_any & bus.req_msel[gnt_idx];
      for (int i = 1; i < RED_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
      for (int i = 1; i < SEL_DELAY; i++) msel_pipe[i] <= msel_pipe[i-1];
      // Registered so the select is stable for the unit's whole final-stage cycle.
      bus.red_modulus_sel <= msel_pipe[SEL_DELAY-1];
      if (gnt_any) begin
        bus.red_in <= bus.req_data[int'(gnt_idx)*60 +: 60];
        rr_ptr     <= rr_next;
      end
    end
  end

  assign push = vld_pipe[RED_LATENCY-1];
  assign pop  = bus.res_valid & bus.res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= '{data: bus.red_out, tag: tag_pipe[RED_LATENCY-1]};
  end

  assign bus.res_valid = (fifo_count != '0);
  assign bus.res_data  = bus.res_valid ? fifo_mem[rd_ptr].data : '0;
  assign bus.res_tag   = bus.res_valid ? fifo_mem[rd_ptr].tag  : '0;
  assign bus.busy      = (|vld_pipe) | bus.res_valid;

  push_into_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && fifo_count == CW'(FIFO_DEPTH)));

`ifdef REDC_SHARE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (gnt_any && perf_issued != '1) perf_issued <= perf_issued + 32'd1;
      if ((|bus.req_valid) && !gnt_any && perf_stall != '1) perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  // Perf counters compiled out; datapath is unchanged.
`endif
endmodule

// File: tb/tb_redc_share_arbiter.sv
// Directed bench for redc_share_arbiter: queue-level reference model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_redc_share_arbiter;
  localparam logic [59:0] QS = 60'h3FFF_C001;
  localparam logic [59:0] QL = 60'h3FFF_8001;
  localparam int          FD = 4;

  typedef struct { logic [59:0] data; logic msel; } src_t;
  typedef struct { logic [29:0] res; logic tag; int due; } op_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0, n_err = 0, cyc = 0, dut_iss = 0;

  redc_share_if #(.NUM_REQ(2)) bus ();

`ifdef REDC_SHARE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
  redc_share_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                          .perf_issued(perf_issued), .perf_stall(perf_stall));
`else
  redc_share_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Stand-in reduction unit: two register stages, final stage reduces with
  // whatever select is presented, so a misaligned select gives a wrong residue.
  logic [59:0] r1, r2;
  always_ff @(posedge clk) begin
    r1 <= bus.red_in;
    r2 <= r1;
  end
  assign bus.red_out = 30'(r2 % (bus.red_modulus_sel ? QL : QS));

  src_t        src [2][$];
  op_t         pend[$], exp_fifo[$];
  bit          selq[$];
  int          m_ptr;
  logic [59:0] m_red_in;
  logic        m_sel;
  logic        got_tags[$];
  logic [29:0] got_data[$];

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_grant();
    if (!rst_n || (exp_fifo.size() + pend.size()) >= FD) return -1;
    for (int k = 0; k < 2; k++) begin
      int idx;
      idx = (m_ptr + k) % 2;
      if (bus.req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic m_reset();
    exp_fifo.delete();
    pend.delete();
    selq.delete();
    selq.push_back(1'b0);
    selq.push_back(1'b0);
    m_ptr = 0;
    m_red_in = '0;
    m_sel = 1'b0;
  endtask

  // Model of one clock edge: pop, land the op issued 3 edges ago, then issue.
  task automatic m_edge();
    int  g;
    op_t op;
    g = m_grant();
    if (!rst_n) return;
    cyc++;
    if (exp_fifo.size() != 0 && bus.res_ready) void'(exp_fifo.pop_front());
    if (pend.size() != 0 && pend[0].due == cyc) exp_fifo.push_back(pend.pop_front());
    m_sel = selq.pop_front();
    selq.push_back(g >= 0 ? src[g][0].msel : 1'b0);
    if (g >= 0) begin
      op.res = 30'(src[g][0].data % (src[g][0].msel ? QL : QS));
      op.tag = 1'(g);
      op.due = cyc + 3;
      pend.push_back(op);
      m_red_in = src[g][0].data;
      m_ptr = (g + 1) % 2;
      void'(src[g].pop_front());
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 2; i++) begin
      bus.req_valid[i]       = (src[i].size() != 0);
      bus.req_data[60*i +: 60] = (src[i].size() != 0) ? src[i][0].data : 60'h0;
      bus.req_msel[i]        = (src[i].size() != 0) ? src[i][0].msel : 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    drive();
  endtask

  task automatic run(int max);
    for (int i = 0; i < max; i++) begin
      if (src[0].size() == 0 && src[1].size() == 0 && !bus.busy) break;
      step();
    end
  endtask

  always @(negedge clk) begin
    int g;
    g = m_grant();
    check("req_ready", 64'(bus.req_ready), (g < 0) ? 64'd0 : (64'd1 << g));
    check("red_in", 64'(bus.red_in), 64'(m_red_in));
    check("red_modulus_sel", 64'(bus.red_modulus_sel), 64'(m_sel));
    check("res_valid", 64'(bus.res_valid), 64'(exp_fifo.size() != 0));
    check("busy", 64'(bus.busy), 64'((exp_fifo.size() + pend.size()) != 0));
    if (exp_fifo.size() != 0) begin
      check("res_data", 64'(bus.res_data), 64'(exp_fifo[0].res));
      check("res_tag", 64'(bus.res_tag), 64'(exp_fifo[0].tag));
    end else if (!rst_n) begin
      check("rst_res_data", 64'(bus.res_data), 64'd0);
      check("rst_res_tag", 64'(bus.res_tag), 64'd0);
    end
    if (bus.res_valid && bus.res_ready) begin
      got_tags.push_back(bus.res_tag[0]);
      got_data.push_back(bus.res_data);
    end
    if (|(bus.req_valid & bus.req_ready)) dut_iss++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    int n0, lat;
    m_reset();
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_msel  = '0;
    bus.res_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // Single op: 0x4000_0001 mod QS = 0x4000, lands 3 edges after issue.
    bus.res_ready = 1'b1;
    src[0].push_back('{60'h0000_0000_4000_0001, 1'b0});
    drive();
    #1 check("single_grant", 64'(bus.req_ready), 64'h1);
    lat = 0;
    for (int i = 0; i < 10 && !bus.res_valid; i++) begin step(); lat++; end
    check("single_latency", 64'(lat), 64'd4);
    check("single_data", 64'(bus.res_data), 64'h4000);
    check("single_tag", 64'(bus.res_tag), 64'd0);
    for (int i = 0; i < 10 && bus.busy; i++) step();
    check("single_busy_fall", 64'(bus.busy), 64'd0);

    // Round-robin: pointer sits at 1 after the single grant to requester 0.
    n0 = got_tags.size();
    for (int k = 0; k < 4; k++) begin
      src[0].push_back('{60'h0_0123_4567_89AB + 60'(k), 1'b0});
      src[1].push_back('{60'h0_0FED_CBA9_8765 + 60'(k), 1'b1});
    end
    drive();
    run(80);
    check("rr_count", 64'(got_tags.size() - n0), 64'd8);
    for (int i = 0; i < 8; i++)
      if (n0 + i < got_tags.size()) check("rr_tag", 64'(got_tags[n0+i]), 64'((i + 1) % 2));

    // Select alignment: same operand, alternating modulus -> 0x4000 / 0x8000.
    n0 = got_data.size();
    dut_iss = 0;
    for (int k = 0; k < 4; k++) src[0].push_back('{60'h0000_0000_4000_0001, 1'(k % 2)});
    drive();
    repeat (4) step();
    check("sel_back_to_back", 64'(dut_iss), 64'd4);
    run(40);
    check("sel_count", 64'(got_data.size() - n0), 64'd4);
    for (int i = 0; i < 4; i++)
      if (n0 + i < got_data.size())
        check("sel_data", 64'(got_data[n0+i]), (i % 2) ? 64'h8000 : 64'h4000);

    // Backpressure: exactly FIFO_DEPTH issues, resume one cycle after first pop.
    bus.res_ready = 1'b0;
    n0 = got_data.size();
    for (int k = 0; k < 3; k++) begin
      src[0].push_back('{60'h0_0000_1111_0000 + 60'(k), 1'b0});
      src[1].push_back('{60'h0_0000_2222_0000 + 60'(k), 1'b1});
    end
    drive();
    dut_iss = 0;
    repeat (8) step();
    check("bp_issues", 64'(dut_iss), 64'd4);
    #1 check("bp_stalled", 64'(bus.req_ready), 64'd0);
    bus.res_ready = 1'b1;
    #1 check("bp_no_credit_at_pop", 64'(bus.req_ready), 64'd0);
    step();
    #1 check("bp_resume", 64'(bus.req_ready != 0), 64'd1);
    run(60);
    check("bp_no_loss", 64'(got_data.size() - n0), 64'd6);

    // Push and pop together with two entries buffered.
    bus.res_ready = 1'b0;
    n0 = got_data.size();
    src[0].push_back('{60'h0_0ABC_0000_0001, 1'b0});
    src[0].push_back('{60'h0_0ABC_0000_0002, 1'b1});
    drive();
    repeat (6) step();
    check("pp_fill", 64'(bus.res_valid), 64'd1);
    for (int k = 0; k < 4; k++) begin
      src[0].push_back('{60'h0_0DEF_0000_0000 + 60'(k), 1'(k % 2)});
      src[1].push_back('{60'h0_0DEF_1000_0000 + 60'(k), 1'(~k % 2)});
    end
    bus.res_ready = 1'b1;
    drive();
    run(80);
    check("pp_count", 64'(got_data.size() - n0), 64'd10);

    // Reset with three ops in flight from requester 0 (pointer left at 1).
    n0 = got_data.size();
    for (int k = 0; k < 3; k++) src[0].push_back('{60'h0_0555_0000_0000 + 60'(k), 1'b0});
    drive();
    repeat (3) step();
    rst_n = 1'b0;
    m_reset();
    src[0].delete();
    src[1].delete();
    drive();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("rst_res_valid", 64'(bus.res_valid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
    end
    check("rst_no_stale", 64'(got_data.size() - n0), 64'd0);
    src[0].push_back('{60'h0_0000_4000_0001, 1'b1});
    src[1].push_back('{60'h0_0000_4000_0001, 1'b0});
    drive();
    #1 check("rst_ptr_restart", 64'(bus.req_ready), 64'h1);
    run(40);
    check("final_idle", 64'(bus.busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
